// File: rtl/bus_capture_log_pkg.sv
// Shared defaults and state encoding for the bus trace capture logger.
package bus_capture_log_pkg;

  localparam int unsigned WIDTH_DEF     = 9;
  localparam int unsigned ADDR_BITS_DEF = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

endpackage

// File: rtl/ram32x9_dp.sv
// Trace RAM: one write port, one registered read port, read-before-write on collision.
module ram32x9_dp #(
  parameter int unsigned WIDTH     = 9,
  parameter int unsigned ADDR_BITS = 5
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 we_i,
  input  logic [ADDR_BITS-1:0] waddr_i,
  input  logic [WIDTH-1:0]     wdata_i,
  input  logic [ADDR_BITS-1:0] raddr_i,
  output logic [WIDTH-1:0]     rdata_o
);

  logic [WIDTH-1:0] mem [2**ADDR_BITS];

  // Contents survive reset; only the read register is cleared.
  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) rdata_o <= '0;
    else       rdata_o <= mem[raddr_i];
  end

endmodule

// File: rtl/bus_capture_log.sv
// Records the processor bus on each rising edge of Done into a 32-entry trace RAM.
module bus_capture_log
  import bus_capture_log_pkg::*;
#(
  parameter int unsigned WIDTH     = WIDTH_DEF,
  parameter int unsigned ADDR_BITS = ADDR_BITS_DEF
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 Arm,
  input  logic                 Stop,
  input  logic                 Done,
  input  logic [WIDTH-1:0]     Bus,
  input  logic [ADDR_BITS-1:0] RdAddr,
  output logic [WIDTH-1:0]     RdData,
  output logic [ADDR_BITS:0]   Count,
  output logic                 Capturing,
  output logic                 Full,
  output logic                 Overflow
);

  localparam logic [ADDR_BITS:0] DepthCnt = (ADDR_BITS+1)'(2**ADDR_BITS);

  state_t               state_q, state_d;
  logic [ADDR_BITS:0]   count_q, count_d;
  logic                 ovf_q, ovf_d;
  logic                 done_q;
  logic                 cap_q, full_q;
  logic                 capture;
  logic                 we;

  assign capture = Done & ~done_q;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    we      = 1'b0;
    // Arm clears from any state and masks a coincident capture event.
    if (Arm) begin
      state_d = ST_ARMED;
      count_d = '0;
      ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: ;
        ST_ARMED: begin
          if (capture) begin
            we      = 1'b1;
            count_d = count_q + 1'b1;
            if (count_d == DepthCnt) state_d = ST_FULL;
          end
          if (Stop) state_d = ST_IDLE;
        end
        ST_FULL: begin
          if (capture) ovf_d = 1'b1;
          if (Stop) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      cap_q   <= 1'b0;
      full_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      done_q  <= Done;
      cap_q   <= (state_d == ST_ARMED);
      full_q  <= (state_d == ST_FULL);
    end
  end

  ram32x9_dp #(
    .WIDTH     (WIDTH),
    .ADDR_BITS (ADDR_BITS)
  ) u_ram (
    .clk_i   (Clock),
    .rst_i   (Reset),
    .we_i    (we),
    .waddr_i (count_q[ADDR_BITS-1:0]),
    .wdata_i (Bus),
    .raddr_i (RdAddr),
    .rdata_o (RdData)
  );

  assign Count     = count_q;
  assign Capturing = cap_q;
  assign Full      = full_q;
  assign Overflow  = ovf_q;

endmodule

// File: tb/tb_bus_capture_log.sv
// Directed table plus hand sequences for the bus trace capture logger.
module tb_bus_capture_log;

  logic       Clock = 1'b0;
  logic       Reset, Arm, Stop, Done;
  logic [8:0] Bus;
  logic [4:0] RdAddr;
  logic [8:0] RdData;
  logic [5:0] Count;
  logic       Capturing, Full, Overflow;

  int nvec = 0;
  int nbad = 0;

  always #5 Clock = ~Clock;

  bus_capture_log dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .Arm       (Arm),
    .Stop      (Stop),
    .Done      (Done),
    .Bus       (Bus),
    .RdAddr    (RdAddr),
    .RdData    (RdData),
    .Count     (Count),
    .Capturing (Capturing),
    .Full      (Full),
    .Overflow  (Overflow)
  );

  typedef struct {
    logic       arm;
    logic       stop;
    logic       done;
    logic [8:0] bus;
    logic [4:0] rdaddr;
    int         cnt;
    logic       cap;
    logic       chk_rd;
    logic [8:0] rd;
  } vec_t;

  vec_t tbl [15];

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nbad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic pulse(input logic [8:0] b);
    Done = 1'b1;
    Bus  = b;
    tick();
    Done = 1'b0;
    tick();
  endtask

  initial begin
    Reset = 1'b1; Arm = 1'b0; Stop = 1'b0; Done = 1'b0; Bus = '0; RdAddr = '0;

    // Reset then idle: Done toggles without Arm are ignored.
    tick(); tick();
    check("rst_count", int'(Count), 0);
    check("rst_cap", int'(Capturing), 0);
    check("rst_full", int'(Full), 0);
    check("rst_ovf", int'(Overflow), 0);
    check("rst_rd", int'(RdData), 0);
    Reset = 1'b0;
    for (int i = 0; i < 3; i++) pulse(9'h055);
    check("idle_count", int'(Count), 0);
    check("idle_cap", int'(Capturing), 0);
    check("idle_ovf", int'(Overflow), 0);

    // arm stop done bus rdaddr | cnt cap chk_rd rd
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 9'h000, 5'd0, 0, 1'b1, 1'b0, 9'h000};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 9'h001, 5'd0, 1, 1'b1, 1'b0, 9'h000};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 9'h000, 5'd0, 1, 1'b1, 1'b0, 9'h000};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 9'h0A5, 5'd0, 2, 1'b1, 1'b0, 9'h000};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 9'h000, 5'd0, 2, 1'b1, 1'b0, 9'h000};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 9'h1FF, 5'd0, 3, 1'b1, 1'b0, 9'h000};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 9'h000, 5'd0, 3, 1'b1, 1'b1, 9'h001};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 9'h000, 5'd1, 3, 1'b1, 1'b1, 9'h0A5};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 9'h000, 5'd2, 3, 1'b1, 1'b1, 9'h1FF};
    // Done held five cycles: only the first high cycle is captured.
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 9'h011, 5'd0, 4, 1'b1, 1'b0, 9'h000};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 9'h022, 5'd0, 4, 1'b1, 1'b0, 9'h000};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 9'h033, 5'd0, 4, 1'b1, 1'b0, 9'h000};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 9'h044, 5'd0, 4, 1'b1, 1'b0, 9'h000};
    tbl[13] = '{1'b0, 1'b0, 1'b1, 9'h055, 5'd0, 4, 1'b1, 1'b0, 9'h000};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 9'h000, 5'd3, 4, 1'b1, 1'b1, 9'h011};

    for (int i = 0; i < 15; i++) begin
      Arm = tbl[i].arm; Stop = tbl[i].stop; Done = tbl[i].done;
      Bus = tbl[i].bus; RdAddr = tbl[i].rdaddr;
      tick();
      check($sformatf("tbl%0d_count", i), int'(Count), tbl[i].cnt);
      check($sformatf("tbl%0d_cap", i), int'(Capturing), int'(tbl[i].cap));
      if (tbl[i].chk_rd) check($sformatf("tbl%0d_rd", i), int'(RdData), int'(tbl[i].rd));
    end
    Arm = 1'b0; Done = 1'b0;

    // Fill and overflow.
    Arm = 1'b1; tick(); Arm = 1'b0;
    for (int k = 0; k < 32; k++) pulse(9'(k));
    check("fill_full", int'(Full), 1);
    check("fill_count", int'(Count), 32);
    check("fill_cap", int'(Capturing), 0);
    check("fill_ovf0", int'(Overflow), 0);
    pulse(9'd32);
    check("ovf_set", int'(Overflow), 1);
    check("ovf_count", int'(Count), 32);
    RdAddr = 5'd31; tick();
    check("ovf_rd31", int'(RdData), 31);
    RdAddr = 5'd0; tick();
    check("ovf_rd0", int'(RdData), 0);
    Arm = 1'b1; tick(); Arm = 1'b0;
    check("rearm_count", int'(Count), 0);
    check("rearm_ovf", int'(Overflow), 0);
    check("rearm_full", int'(Full), 0);
    check("rearm_cap", int'(Capturing), 1);

    // Simultaneous events.
    Stop = 1'b1; tick(); Stop = 1'b0;
    check("stop_cap", int'(Capturing), 0);
    Arm = 1'b1; Stop = 1'b1; tick(); Arm = 1'b0; Stop = 1'b0;
    check("armstop_cap", int'(Capturing), 1);
    Arm = 1'b1; Done = 1'b1; Bus = 9'h077; tick(); Arm = 1'b0; Done = 1'b0; tick();
    check("armdone_count", int'(Count), 0);
    for (int k = 0; k < 4; k++) pulse(9'h100 + 9'(k));
    check("pre4_count", int'(Count), 4);
    // Address 4 still holds 4 from the fill; write and read it together.
    RdAddr = 5'd4; Done = 1'b1; Bus = 9'h1AB; tick(); Done = 1'b0;
    check("rbw_old", int'(RdData), 4);
    check("rbw_count", int'(Count), 5);
    tick();
    check("rbw_new", int'(RdData), 9'h1AB);
    Stop = 1'b1; Done = 1'b1; Bus = 9'h0CC; tick(); Stop = 1'b0; Done = 1'b0;
    check("stopdone_count", int'(Count), 6);
    check("stopdone_cap", int'(Capturing), 0);
    RdAddr = 5'd5; tick();
    check("stopdone_rd", int'(RdData), 9'h0CC);
    pulse(9'h0EE);
    check("idle2_count", int'(Count), 6);

    // Reset mid-capture.
    Arm = 1'b1; tick(); Arm = 1'b0;
    for (int k = 0; k < 10; k++) pulse(9'h050 + 9'(k));
    check("mid_count", int'(Count), 10);
    Reset = 1'b1; tick(); Reset = 1'b0;
    check("midrst_count", int'(Count), 0);
    check("midrst_cap", int'(Capturing), 0);
    pulse(9'h0AA);
    check("midrst_ign_count", int'(Count), 0);
    check("midrst_ign_cap", int'(Capturing), 0);
    RdAddr = 5'd0; tick();
    check("midrst_mem", int'(RdData), 9'h050);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule

// File: doc/bus_capture_log.md
# bus_capture_log

Write-side companion to the ROM-fed processor: the ROM streams instruction words into the processor's DIN, and this block records what comes back out on the processor's 9-bit bus. On every completed instruction (rising edge of `Done`) it writes the bus value into an internal 32x9 RAM. The stored trace is read back through a synchronous read port for display or checking. It sits beside the processor, sharing the processor clock `Clock`.

## Interface
Parameters:
- `WIDTH`, 9: captured word width; equals the processor bus width.
- `ADDR_BITS`, 5: log2 of trace depth (32 entries).

Ports:
- `Clock`  in  1  single clock; all state updates on its rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `Arm`  in  1  one-cycle pulse: clear the trace and start capturing.
- `Stop`  in  1  one-cycle pulse: stop capturing, keep the trace.
- `Done`  in  1  processor instruction-complete flag; level, may stay high for more than one cycle.
- `Bus`  in  WIDTH  processor bus value.
- `RdAddr`  in  ADDR_BITS  trace read address.
- `RdData`  out  WIDTH  trace word at `RdAddr`, registered.
- `Count`  out  ADDR_BITS+1  number of valid entries, 0..32.
- `Capturing`  out  1  high in state ARMED.
- `Full`  out  1  high when `Count` == 32.
- `Overflow`  out  1  sticky: a capture event arrived while FULL.

## Operation
- Edge detector:
  - `done_q` register holds the previous value of `Done`.
  - Capture event = `Done & ~done_q`.
  - `done_q` updates in every state, so a `Done` level already high at arm time is not an event.
- State machine: IDLE, ARMED, FULL.
  - IDLE: ignores events. `Arm` → ARMED, `Count` := 0, `Overflow` := 0.
  - ARMED, on an event:
    - write `Bus` at address `Count[ADDR_BITS-1:0]`;
    - `Count` += 1;
    - if the new `Count` == 32 → FULL.
  - ARMED: `Stop` → IDLE.
  - FULL: no writes. An event sets `Overflow`. `Stop` → IDLE; `Arm` → ARMED (cleared).
- Simultaneous events:
  - `Arm` and `Stop` in the same cycle: `Arm` wins.
  - `Arm` and a capture event in the same cycle: clear only; the event is not recorded.
  - `Stop` and a capture event in the same cycle while ARMED: the event is recorded, then IDLE.
- The write address never wraps; the trace stops at 32 entries. `Count` is the only fill pointer.
- Memory contents are not cleared by `Reset` or `Arm`. Entries at or above `Count` are don't-care.
- Reads are allowed in any state.
- Same-cycle write and read of the same address: `RdData` returns the old word (read-before-write).

## Timing
- Reset, synchronous:
  - state IDLE, `Count`=0, `Full`=0, `Overflow`=0, `Capturing`=0, `done_q`=0;
  - `RdData`=0 on the cycle after reset is sampled.
- Capture latency:
  - `Done` rises at edge N (sampled high at edge N, low at N-1).
  - Bus word is written at edge N.
  - `Count` increments at edge N.
  - The word is readable in `RdData` after edge N+2 when `RdAddr` is presented at edge N+1.
- Read latency: 1 cycle, address registered on the edge.
- `Full` and `Capturing` are registered decodes of state; they change at the same edge as the state.
- `Overflow` sets at the edge sampling the event and holds until `Arm` or `Reset`.
- Reset mid-capture: state is cleared at that edge; memory keeps its contents; the next capture needs `Arm`.

## Structure
- Shared include file:
  - `WIDTH` and `ADDR_BITS` defaults;
  - state encodings `ST_IDLE`=2'd0, `ST_ARMED`=2'd1, `ST_FULL`=2'd2.
- One sub-module, `ram32x9_dp`:
  - one write port and one registered read port;
  - same-address read-before-write behaviour;
  - parameterised on `WIDTH` and `ADDR_BITS`.
- Top level holds the edge detector, the FSM, `Count` and the flag registers.

## Test plan
- Reset then idle: apply `Reset` 2 cycles, toggle `Done` 3 times without `Arm` → `Count`=0, `Capturing`=0, `Overflow`=0.
- Basic capture:
  - stimulus: `Arm`; `Done` pulses with `Bus`=9'h001, 9'h0A5, 9'h1FF;
  - response: `Count`=3; reading addresses 0, 1, 2 gives 9'h001, 9'h0A5, 9'h1FF, each one cycle after its address.
- Long `Done`: `Done` held high 5 cycles with `Bus` changing each cycle → exactly one entry, holding the `Bus` value of the first high cycle.
- Fill and overflow:
  - stimulus: 33 `Done` pulses carrying `Bus`=k for k = 0..32;
  - response after the 32nd pulse: `Full`=1, `Count`=32;
  - response after the 33rd pulse: `Overflow`=1, address 31 still holds 9'd31.
  - Then `Arm` → `Count`=0, `Overflow`=0, `Full`=0.
- Simultaneous events:
  - `Arm`+`Stop` in one cycle → ARMED;
  - `Stop` + `Done` rise while ARMED → entry recorded, state IDLE;
  - read and write of address 4 in one cycle → `RdData` shows the previous word.
- Reset mid-capture: after 10 captures, assert `Reset` → `Count`=0, IDLE; a following `Done` pulse is ignored.
